mips_instr_encoder: RTL and testbench

Streaming MIPS instruction encoder: the inverse of the decode stage. Accepts one symbolic instruction per handshake (mnemonic code plus register/immediate fields), packs it into a 32-bit MIPS word, and assigns it a sequential instruction-memory address. It also computes PC-relative branch offsets, resolves jump targets and expands the `li` pseudo-instruction into one or two words. Used by the test harness and boot-loader path to fill IM for the P5 pipeline.

---
 rtl/mips_instr_encoder_if.sv | 28 ++
 rtl/mips_instr_encoder.sv | 167 ++++++++++++++++
 tb/tb_mips_instr_encoder.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_instr_encoder_if.sv
// Handshake bundle for the MIPS instruction encoder: symbolic input stream,
// encoded output stream and the sticky error report.
interface mips_instr_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_mn;
  logic [4:0]  in_rs;
  logic [4:0]  in_rt;
  logic [4:0]  in_rd;
  logic [4:0]  in_shamt;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic        err;
  logic [1:0]  err_code;

  modport master (
    output in_valid, in_mn, in_rs, in_rt, in_rd, in_shamt, in_imm, out_ready,
    input  in_ready, out_valid, out_instr, out_addr, err, err_code
  );

  modport slave (
    input  in_valid, in_mn, in_rs, in_rt, in_rd, in_shamt, in_imm, out_ready,
    output in_ready, out_valid, out_instr, out_addr, err, err_code
  );
endinterface

// File: rtl/mips_instr_encoder.sv
// Streaming MIPS encoder: packs symbolic instructions into 32-bit words with
// sequential IM addresses, resolving branch/jump targets and expanding LI.
module mips_instr_encoder #(
  parameter logic [31:0] BASE = 32'h0000_3000
) (
  input logic               clk,
  input logic               reset,
  mips_instr_encoder_if.slave bus
);

  typedef enum logic {IDLE, LI2} state_t;

  typedef enum logic [4:0] {
    MN_NOP   = 5'd0,  MN_ADDU  = 5'd1,  MN_SUBU = 5'd2,  MN_AND  = 5'd3,
    MN_SLT   = 5'd4,  MN_SLL   = 5'd5,  MN_JR   = 5'd6,  MN_JALR = 5'd7,
    MN_ADDIU = 5'd8,  MN_ORI   = 5'd9,  MN_LUI  = 5'd10, MN_LW   = 5'd11,
    MN_LH    = 5'd12, MN_LHU   = 5'd13, MN_LB   = 5'd14, MN_LBU  = 5'd15,
    MN_SW    = 5'd16, MN_SH    = 5'd17, MN_SB   = 5'd18, MN_BEQ  = 5'd19,
    MN_BLEZ  = 5'd20, MN_BLTZ  = 5'd21, MN_J    = 5'd22, MN_JAL  = 5'd23,
    MN_LI    = 5'd24
  } mn_t;

  state_t      state_q;
  logic [31:0] wpc_q;
  logic        out_valid_q;
  logic [31:0] out_instr_q;
  logic [31:0] out_addr_q;
  logic [31:0] ori_q;
  logic        err_q;
  logic [1:0]  err_code_q;

  logic        in_ready;
  logic        accept;
  logic        drain;
  logic [31:0] pc4;
  logic [31:0] boff;
  logic        br_ok;
  logic        jmp_ok;
  logic        li_se;
  logic [31:0] instr_d;
  logic [31:0] ori_d;
  logic        two_word;
  logic        enc_err;
  logic [1:0]  enc_code;

  assign in_ready = (state_q == IDLE) && (!out_valid_q || bus.out_ready);
  assign accept   = bus.in_valid && in_ready;
  assign drain    = out_valid_q && bus.out_ready;

  always_comb begin
    pc4      = wpc_q + 32'd4;
    boff     = $signed(bus.in_imm - pc4) >>> 2;
    br_ok    = (bus.in_imm[1:0] == 2'b00) &&
               ((boff[31:15] == '0) || (boff[31:15] == '1));
    jmp_ok   = (bus.in_imm[1:0] == 2'b00) && (bus.in_imm[31:28] == pc4[31:28]);
    li_se    = (bus.in_imm[31:15] == '0) || (bus.in_imm[31:15] == '1);
    ori_d    = {6'h0d, bus.in_rt, bus.in_rt, bus.in_imm[15:0]};
    instr_d  = '0;
    two_word = 1'b0;
    enc_err  = 1'b0;
    enc_code = 2'd0;
    case (bus.in_mn)
      MN_NOP:   instr_d = '0;
      MN_ADDU:  instr_d = {6'h00, bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, 6'h21};
      MN_SUBU:  instr_d = {6'h00, bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, 6'h23};
      MN_AND:   instr_d = {6'h00, bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, 6'h24};
      MN_SLT:   instr_d = {6'h00, bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, 6'h2a};
      MN_SLL:   instr_d = {6'h00, 5'd0, bus.in_rt, bus.in_rd, bus.in_shamt, 6'h00};
      MN_JR:    instr_d = {6'h00, bus.in_rs, 15'd0, 6'h08};
      MN_JALR:  instr_d = {6'h00, bus.in_rs, 5'd0, bus.in_rd, 5'd0, 6'h09};
      MN_ADDIU: instr_d = {6'h09, bus.in_rs, bus.in_rt, bus.in_imm[15:0]};
      MN_ORI:   instr_d = {6'h0d, bus.in_rs, bus.in_rt, bus.in_imm[15:0]};
      MN_LUI:   instr_d = {6'h0f, 5'd0, bus.in_rt, bus.in_imm[15:0]};
      MN_LW:    instr_d = {6'h23, bus.in_rs, bus.in_rt, bus.in_imm[15:0]};
      MN_LH:    instr_d = {6'h21, bus.in_rs, bus.in_rt, bus.in_imm[15:0]};
      MN_LHU:   instr_d = {6'h25, bus.in_rs, bus.in_rt, bus.in_imm[15:0]};
      MN_LB:    instr_d = {6'h20, bus.in_rs, bus.in_rt, bus.in_imm[15:0]};
      MN_LBU:   instr_d = {6'h24, bus.in_rs, bus.in_rt, bus.in_imm[15:0]};
      MN_SW:    instr_d = {6'h2b, bus.in_rs, bus.in_rt, bus.in_imm[15:0]};
      MN_SH:    instr_d = {6'h29, bus.in_rs, bus.in_rt, bus.in_imm[15:0]};
      MN_SB:    instr_d = {6'h28, bus.in_rs, bus.in_rt, bus.in_imm[15:0]};
      MN_BEQ, MN_BLEZ, MN_BLTZ: begin
        case (bus.in_mn)
          MN_BEQ:  instr_d = {6'h04, bus.in_rs, bus.in_rt, boff[15:0]};
          MN_BLEZ: instr_d = {6'h06, bus.in_rs, 5'd0, boff[15:0]};
          default: instr_d = {6'h01, bus.in_rs, 5'd0, boff[15:0]};
        endcase
        if (!br_ok) begin
          enc_err  = 1'b1;
          enc_code = 2'd2;
        end
      end
      MN_J, MN_JAL: begin
        instr_d = {(bus.in_mn == MN_J) ? 6'h02 : 6'h03, bus.in_imm[27:2]};
        if (!jmp_ok) begin
          enc_err  = 1'b1;
          enc_code = 2'd3;
        end
      end
      MN_LI: begin
        if (li_se) begin
          instr_d = {6'h09, 5'd0, bus.in_rt, bus.in_imm[15:0]};
        end else begin
          instr_d  = {6'h0f, 5'd0, bus.in_rt, bus.in_imm[31:16]};
          two_word = (bus.in_imm[15:0] != '0);
        end
      end
      default: begin
        enc_err  = 1'b1;
        enc_code = 2'd1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      wpc_q       <= BASE;
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_addr_q  <= BASE;
      ori_q       <= '0;
      err_q       <= 1'b0;
      err_code_q  <= 2'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (enc_err) begin
              // Accept implies the output was empty or draining, so it empties.
              out_valid_q <= 1'b0;
              err_q       <= 1'b1;
              if (!err_q) err_code_q <= enc_code;
            end else begin
              out_valid_q <= 1'b1;
              out_instr_q <= instr_d;
              out_addr_q  <= wpc_q;
              wpc_q       <= pc4;
              if (two_word) begin
                ori_q   <= ori_d;
                state_q <= LI2;
              end
            end
          end else if (drain) begin
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          if (drain) begin
            out_instr_q <= ori_q;
            out_addr_q  <= wpc_q;
            wpc_q       <= pc4;
            state_q     <= IDLE;
          end
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_instr = out_instr_q;
  assign bus.out_addr  = out_addr_q;
  assign bus.err       = err_q;
  assign bus.err_code  = err_code_q;

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Bench for mips_instr_encoder: directed scenarios plus randomized traffic
// scored against an arithmetic model of the instruction encodings.
module tb_mips_instr_encoder;
  localparam logic [31:0] BASE = 32'h0000_3000;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mips_instr_encoder_if bus();

  mips_instr_encoder #(.BASE(BASE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit rand_en = 1'b0;

  logic [31:0] m_wpc = BASE;
  bit          m_err = 1'b0;
  logic [1:0]  m_code = 2'd0;
  logic [31:0] q_instr[$];
  logic [31:0] q_addr[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] r_word(input longint unsigned rs, rt, rd, sh, fn);
    return 32'(rs * 2097152 + rt * 65536 + rd * 2048 + sh * 64 + fn);
  endfunction

  function automatic logic [31:0] i_word(input longint unsigned op, rs, rt, imm16);
    return 32'(op * 67108864 + rs * 2097152 + rt * 65536 + imm16);
  endfunction

  function automatic void model_enc(
    input  int unsigned mn, rs, rt, rd, sh,
    input  logic [31:0] imm, pc,
    output int n, output logic [31:0] w0, output logic [31:0] w1, output int ec);
    logic [31:0] dd;
    logic [31:0] p4;
    int          sd;
    int          off;
    longint unsigned lo, hi, u;
    u  = longint'(imm);
    lo = u % 65536;
    hi = u / 65536;
    p4 = pc + 32'd4;
    n = 1; w0 = '0; w1 = '0; ec = 0;
    case (mn)
      0:  w0 = '0;
      1:  w0 = r_word(rs, rt, rd, 0, 'h21);
      2:  w0 = r_word(rs, rt, rd, 0, 'h23);
      3:  w0 = r_word(rs, rt, rd, 0, 'h24);
      4:  w0 = r_word(rs, rt, rd, 0, 'h2a);
      5:  w0 = r_word(0, rt, rd, sh, 'h00);
      6:  w0 = r_word(rs, 0, 0, 0, 'h08);
      7:  w0 = r_word(rs, 0, rd, 0, 'h09);
      8:  w0 = i_word('h09, rs, rt, lo);
      9:  w0 = i_word('h0d, rs, rt, lo);
      10: w0 = i_word('h0f, 0, rt, lo);
      11: w0 = i_word('h23, rs, rt, lo);
      12: w0 = i_word('h21, rs, rt, lo);
      13: w0 = i_word('h25, rs, rt, lo);
      14: w0 = i_word('h20, rs, rt, lo);
      15: w0 = i_word('h24, rs, rt, lo);
      16: w0 = i_word('h2b, rs, rt, lo);
      17: w0 = i_word('h29, rs, rt, lo);
      18: w0 = i_word('h28, rs, rt, lo);
      19, 20, 21: begin
        dd = imm - p4;
        sd = $signed(dd);
        if (u % 4 != 0) ec = 2;
        else begin
          off = sd / 4;
          if (off < -32768 || off > 32767) ec = 2;
          else begin
            lo = longint'(off & 65535);
            if (mn == 19)      w0 = i_word('h04, rs, rt, lo);
            else if (mn == 20) w0 = i_word('h06, rs, 0, lo);
            else               w0 = i_word('h01, rs, 0, lo);
          end
        end
      end
      22, 23: begin
        if (u % 4 != 0 || u / 268435456 != longint'(p4) / 268435456) ec = 3;
        else w0 = 32'(((mn == 22) ? 2 : 3) * 67108864 + (u % 268435456) / 4);
      end
      24: begin
        sd = $signed(imm);
        if (sd >= -32768 && sd <= 32767) w0 = i_word('h09, 0, rt, lo);
        else if (lo == 0) w0 = i_word('h0f, 0, rt, hi);
        else begin
          n  = 2;
          w0 = i_word('h0f, 0, rt, hi);
          w1 = i_word('h0d, rt, rt, lo);
        end
      end
      default: ec = 1;
    endcase
    if (ec != 0) n = 0;
  endfunction

  task automatic model_accept();
    int n, ec;
    logic [31:0] w0, w1;
    model_enc(bus.in_mn, bus.in_rs, bus.in_rt, bus.in_rd, bus.in_shamt,
              bus.in_imm, m_wpc, n, w0, w1, ec);
    if (ec != 0) begin
      if (!m_err) m_code = 2'(ec);
      m_err = 1'b1;
    end else begin
      q_instr.push_back(w0); q_addr.push_back(m_wpc); m_wpc += 32'd4;
      if (n == 2) begin
        q_instr.push_back(w1); q_addr.push_back(m_wpc); m_wpc += 32'd4;
      end
    end
  endtask

  // Scoreboard: outputs are sampled mid-cycle, before the edge that acts on them.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        m_wpc = BASE; m_err = 1'b0; m_code = 2'd0;
        q_instr.delete(); q_addr.delete();
      end else begin
        check("err", 32'(bus.err), 32'(m_err));
        check("err_code", 32'(bus.err_code), 32'(m_code));
        if (bus.out_valid && bus.out_ready) begin
          if (q_instr.size() == 0) check("spurious_word", 32'(q_instr.size()), 32'd1);
          else begin
            check("sb_instr", bus.out_instr, q_instr.pop_front());
            check("sb_addr", bus.out_addr, q_addr.pop_front());
          end
        end
        if (bus.in_valid && bus.in_ready) model_accept();
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_en) bus.out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    bus.in_valid = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic set_in(input logic [4:0] mn, rs, rt, rd, sh, input logic [31:0] imm);
    bus.in_mn = mn; bus.in_rs = rs; bus.in_rt = rt; bus.in_rd = rd;
    bus.in_shamt = sh; bus.in_imm = imm; bus.in_valid = 1'b1;
  endtask

  task automatic send(input logic [4:0] mn, rs, rt, rd, sh, input logic [31:0] imm);
    int k;
    set_in(mn, rs, rt, rd, sh, imm);
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (bus.in_ready) break;
    end
    if (k == 200) check("accept_timeout", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic chk_word(input string tag, input logic [31:0] instr, input logic [31:0] addr);
    check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    check({tag, "_instr"}, bus.out_instr, instr);
    check({tag, "_addr"}, bus.out_addr, addr);
  endtask

  initial begin
    logic [31:0] r32, p4, imm;
    int          off, sel;
    logic [4:0]  mn;
    bus.in_valid = 1'b0; bus.in_mn = '0; bus.in_rs = '0; bus.in_rt = '0;
    bus.in_rd = '0; bus.in_shamt = '0; bus.in_imm = '0; bus.out_ready = 1'b1;
    tick(); tick();
    reset = 1'b1;

    @(negedge clk);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_err", 32'(bus.err), 32'd0);
    check("rst_err_code", 32'(bus.err_code), 32'd0);
    check("rst_out_instr", bus.out_instr, 32'd0);
    tick();

    send(5'd1, 5'd1, 5'd2, 5'd3, 5'd0, 32'd0);
    @(negedge clk); chk_word("addu", 32'h0022_1821, 32'h3000);
    tick();
    send(5'd0, 5'd7, 5'd7, 5'd7, 5'd7, 32'hFFFF_FFFF);
    @(negedge clk); chk_word("nop", 32'h0000_0000, 32'h3004);
    tick();

    do_reset();
    send(5'd24, 5'd0, 5'd8, 5'd0, 5'd0, 32'h1234_5678);
    @(negedge clk); chk_word("li_lui", 32'h3C08_1234, 32'h3000);
    check("li2_in_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk); chk_word("li_ori", 32'h3508_5678, 32'h3004);
    tick();
    send(5'd24, 5'd0, 5'd8, 5'd0, 5'd0, 32'hFFFF_FFFF);
    @(negedge clk); chk_word("li_se", 32'h2408_FFFF, 32'h3008);
    tick();
    send(5'd24, 5'd0, 5'd8, 5'd0, 5'd0, 32'h0005_0000);
    @(negedge clk); chk_word("li_hi", 32'h3C08_0005, 32'h300C);
    tick();

    do_reset();
    send(5'd19, 5'd1, 5'd2, 5'd0, 5'd0, 32'h0002_3004);
    @(negedge clk);
    check("br_far_valid", 32'(bus.out_valid), 32'd0);
    check("br_far_err", 32'(bus.err), 32'd1);
    check("br_far_code", 32'(bus.err_code), 32'd2);
    tick();
    send(5'd19, 5'd1, 5'd2, 5'd0, 5'd0, 32'h0000_2FFC);
    @(negedge clk); chk_word("beq", 32'h1022_FFFE, 32'h3000);
    tick();
    send(5'd27, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    @(negedge clk); check("ill_keeps_code", 32'(bus.err_code), 32'd2);
    tick();

    do_reset();
    send(5'd23, 5'd0, 5'd0, 5'd0, 5'd0, 32'h0000_3010);
    @(negedge clk); chk_word("jal", 32'h0C00_0C04, 32'h3000);
    tick();
    send(5'd22, 5'd0, 5'd0, 5'd0, 5'd0, 32'h1000_0000);
    @(negedge clk); check("j_region_code", 32'(bus.err_code), 32'd3);
    tick();

    do_reset();
    bus.out_ready = 1'b0;
    send(5'd11, 5'd29, 5'd4, 5'd0, 5'd0, 32'h0000_0010);
    set_in(5'd1, 5'd1, 5'd2, 5'd3, 5'd0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_word("bp_hold", 32'h8FA4_0010, 32'h3000);
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
      tick();
    end
    bus.out_ready = 1'b1;
    @(negedge clk); check("bp_release_ready", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    @(negedge clk); chk_word("bp_next", 32'h0022_1821, 32'h3004);
    tick();

    do_reset();
    send(5'd27, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    bus.out_ready = 1'b0;
    send(5'd24, 5'd0, 5'd8, 5'd0, 5'd0, 32'h1234_5678);
    @(negedge clk); check("li2_hold_ready", 32'(bus.in_ready), 32'd0);
    tick();
    do_reset();
    @(negedge clk);
    check("li2_rst_valid", 32'(bus.out_valid), 32'd0);
    check("li2_rst_err", 32'(bus.err), 32'd0);
    check("li2_rst_ready", 32'(bus.in_ready), 32'd1);
    tick();
    bus.out_ready = 1'b1;
    send(5'd1, 5'd1, 5'd2, 5'd3, 5'd0, 32'd0);
    @(negedge clk); chk_word("post_rst", 32'h0022_1821, 32'h3000);
    tick();

    do_reset();
    rand_en = 1'b1;
    for (int it = 0; it < 400; it++) begin
      mn  = ($urandom_range(0, 99) < 96) ? 5'($urandom_range(0, 24)) : 5'($urandom_range(25, 31));
      r32 = $urandom();
      p4  = m_wpc + 32'd4;
      sel = $urandom_range(0, 9);
      imm = r32;
      if (mn >= 5'd19 && mn <= 5'd21) begin
        case (sel)
          0: imm = r32;
          1: imm = p4 + 32'($urandom_range(1, 3));
          2: imm = p4 + 32'(32767 * 4);
          3: imm = p4 - 32'(32768 * 4);
          4: imm = p4 + 32'(32768 * 4);
          default: begin
            off = int'($urandom_range(0, 65535)) - 32768;
            imm = p4 + 32'(off * 4);
          end
        endcase
      end else if (mn == 5'd22 || mn == 5'd23) begin
        if (sel > 1) imm = {p4[31:28], r32[27:2], 2'b00};
      end else if (mn == 5'd24) begin
        case (sel)
          0: imm = 32'h0000_7FFF;
          1: imm = 32'h0000_8000;
          2: imm = 32'hFFFF_8000;
          3: imm = 32'hFFFF_7FFF;
          4, 5: imm = {r32[31:16], 16'h0000};
          6: imm = 32'($urandom_range(0, 65535)) - 32'd32768;
          default: imm = r32;
        endcase
      end
      for (int g = $urandom_range(0, 2); g > 0; g--) tick();
      send(mn, 5'($urandom()), 5'($urandom()), 5'($urandom()), 5'($urandom()), imm);
    end
    rand_en = 1'b0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 50 && q_instr.size() != 0; k++) @(negedge clk);
    @(negedge clk);
    check("final_queue_empty", 32'(q_instr.size()), 32'd0);
    check("final_out_valid", 32'(bus.out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
